// File: rtl/spec_byte_serializer.sv
// Frame-to-byte-stream serializer: captures a whole spectrum frame and emits it byte by byte
// on a ready/valid stream. Optional frame-counter header controlled by macro SPEC_SER_SEQ_HDR_EN.
module spec_byte_serializer #(
   parameter int N_BYTES = 8,
   parameter int SEQ_W   = 32
) (
   input  logic                    clk,
   input  logic                    srst,
   input  logic                    in_valid,
   input  logic [N_BYTES-1:0][7:0] in_data,
   output logic [7:0]              m_tdata,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic                    m_tlast,
   output logic                    busy,
   output logic [15:0]             drop_cnt
);

   if ((SEQ_W % 8) != 0 || SEQ_W < 8 || SEQ_W > 32) begin : g_bad_seq_w
      $error("SEQ_W must be a multiple of 8 in the range 8..32");
   end

`ifdef SPEC_SER_SEQ_HDR_EN
   localparam int HDR_BYTES = SEQ_W / 8;
   localparam int MAX_LEN   = (N_BYTES > HDR_BYTES) ? N_BYTES : HDR_BYTES;
   typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;
   localparam state_t FIRST = HDR;
`else
   localparam int MAX_LEN = N_BYTES;
   typedef enum logic [1:0] {IDLE = 2'd0, PAY = 2'd2} state_t;
   localparam state_t FIRST = PAY;
`endif
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t                  state, state_n;
   logic [IDX_W-1:0]        idx;
   logic [N_BYTES-1:0][7:0] frame_p0;
   logic                    xfer;
   logic                    last_byte;
   logic                    tlast_xfer;
   logic                    capture;
   logic                    drop;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign xfer       = m_tvalid & m_tready;
   assign last_byte  = (state == PAY) && (idx == IDX_W'(N_BYTES - 1));
   assign tlast_xfer = xfer & last_byte;
   // A frame arriving exactly on the tlast transfer chains on without a bubble.
   assign capture    = in_valid & ((state == IDLE) | tlast_xfer);
   assign drop       = in_valid & (state != IDLE) & ~tlast_xfer;

`ifdef SPEC_SER_SEQ_HDR_EN
   logic [SEQ_W-1:0]          seq_cnt;
   logic [SEQ_W-1:0]          seq_next;
   logic [HDR_BYTES-1:0][7:0] hdr_p0;
   logic                      hdr_last;

   assign seq_next = tlast_xfer ? seq_cnt + SEQ_W'(1) : seq_cnt;
   assign hdr_last = (idx == IDX_W'(HDR_BYTES - 1));

   always_ff @(posedge clk) begin
      if (srst) begin
         seq_cnt <= '0;
      end else begin
         seq_cnt <= seq_next;
      end
   end

   // Header value is latched with the frame so it reflects a count bumped by a coincident tlast.
   always_ff @(posedge clk) begin
      if (capture) begin
         hdr_p0 <= seq_next;
      end
   end
`endif

   // Capture stage: frame payload register (data only, no reset)
   always_ff @(posedge clk) begin
      if (capture) begin
         frame_p0 <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_n = FIRST;
            end
         end
`ifdef SPEC_SER_SEQ_HDR_EN
         HDR: begin
            if (xfer && hdr_last) begin
               state_n = PAY;
            end
         end
`endif
         PAY: begin
            if (tlast_xfer) begin
               state_n = in_valid ? FIRST : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         idx <= '0;
      end else if (capture) begin
         idx <= '0;
      end else if (xfer) begin
`ifdef SPEC_SER_SEQ_HDR_EN
         if (last_byte || ((state == HDR) && hdr_last)) begin
`else
         if (last_byte) begin
`endif
            idx <= '0;
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         drop_cnt <= '0;
      end else if (drop) begin
         drop_cnt <= sat_inc16(drop_cnt);
      end
   end

   always_comb begin
      m_tvalid = (state != IDLE);
      busy     = (state != IDLE);
      m_tlast  = 1'b0;
      m_tdata  = '0;
      case (state)
`ifdef SPEC_SER_SEQ_HDR_EN
         HDR: begin
            for (int i = 0; i < HDR_BYTES; i++) begin
               if (idx == IDX_W'(i)) begin
                  m_tdata = hdr_p0[HDR_BYTES-1-i];
               end
            end
         end
`endif
         PAY: begin
            for (int i = 0; i < N_BYTES; i++) begin
               if (idx == IDX_W'(i)) begin
                  m_tdata = frame_p0[i];
               end
            end
            m_tlast = last_byte;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spec_byte_serializer.sv
// Directed self-checking bench for spec_byte_serializer; follows SPEC_SER_SEQ_HDR_EN like the design.
module tb_spec_byte_serializer;

   localparam int N = 8;
`ifdef SPEC_SER_SEQ_HDR_EN
   localparam int HDR = 4;
`else
   localparam int HDR = 0;
`endif
   localparam int FL = HDR + N;

   logic              clk = 1'b0;
   logic              srst;
   logic              in_valid;
   logic [N-1:0][7:0] in_data;
   logic [7:0]        m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;
   logic              busy;
   logic [15:0]       drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   spec_byte_serializer #(.N_BYTES(N), .SEQ_W(32)) dut (
      .clk      (clk),
      .srst     (srst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0][7:0] mk(input logic [7:0] base);
      logic [N-1:0][7:0] d;
      for (int i = 0; i < N; i++) d[i] = base + 8'(i);
      return d;
   endfunction

   function automatic logic [7:0] exp_byte(input logic [31:0] seq, input logic [7:0] base, input int k);
      if (k < HDR) return 8'(seq >> (8 * (HDR - 1 - k)));
      return base + 8'(k - HDR);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      srst = 1'b1; in_valid = 1'b0; m_tready = 1'b1; in_data = '0;
      repeat (2) @(negedge clk);
      check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("rst_tlast",  {31'd0, m_tlast},  32'd0);
      check("rst_tdata",  {24'd0, m_tdata},  32'd0);
      check("rst_busy",   {31'd0, busy},     32'd0);
      check("rst_drop",   {16'd0, drop_cnt}, 32'd0);
      srst = 1'b0;
   endtask

   // Called at a negedge in IDLE; returns at the negedge where the first byte is presented.
   task automatic start_frame(input logic [7:0] base);
      in_data = mk(base); in_valid = 1'b1; m_tready = 1'b1;
      check("pre_tvalid", {31'd0, m_tvalid}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check("latency_tvalid", {31'd0, m_tvalid}, 32'd1);
   endtask

   task automatic expect_frame(input logic [31:0] seq, input logic [7:0] base, input bit stall,
                               input bit chain, input logic [7:0] cbase, input int drop_at);
      int k = 0;
      int c = 0;
      while (k < FL && c < 200) begin
         in_valid = 1'b0;
         if (c == drop_at) begin
            in_valid = 1'b1; in_data = mk(8'h99);
         end
         m_tready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         check("tvalid", {31'd0, m_tvalid}, 32'd1);
         check("tdata",  {24'd0, m_tdata}, {24'd0, exp_byte(seq, base, k)});
         check("tlast",  {31'd0, m_tlast}, {31'd0, (k == FL - 1)});
         if (m_tready) begin
            if (k == FL - 1 && chain) begin
               in_valid = 1'b1; in_data = mk(cbase);
            end
            k++;
         end
         c++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      m_tready = 1'b1;
      if (k < FL) check("frame_timeout", k, FL);
   endtask

   initial begin
      srst = 1'b1; in_valid = 1'b0; m_tready = 1'b1; in_data = '0;

      // Single frame, ready always high
      do_reset();
      start_frame(8'h01);
      expect_frame(32'h0, 8'h01, 1'b0, 1'b0, 8'h00, -1);
      check("A_idle_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("A_idle_busy",   {31'd0, busy},     32'd0);

      // Backpressure 1,0,0,1
      do_reset();
      start_frame(8'h01);
      expect_frame(32'h0, 8'h01, 1'b1, 1'b0, 8'h00, -1);
      check("B_idle_tvalid", {31'd0, m_tvalid}, 32'd0);

      // Drop while busy, three clocks after the first strobe
      do_reset();
      start_frame(8'h21);
      expect_frame(32'h0, 8'h21, 1'b0, 1'b0, 8'h00, 2);
      check("C_drop_cnt", {16'd0, drop_cnt}, 32'd1);
      check("C_idle_tvalid", {31'd0, m_tvalid}, 32'd0);
      start_frame(8'h31);
      expect_frame(32'h1, 8'h31, 1'b0, 1'b0, 8'h00, -1);
      check("C_drop_cnt_hold", {16'd0, drop_cnt}, 32'd1);

      // New frame on the tlast transfer: no bubble
      do_reset();
      start_frame(8'h41);
      expect_frame(32'h0, 8'h41, 1'b0, 1'b1, 8'h51, -1);
      check("D_nobubble", {31'd0, m_tvalid}, 32'd1);
      expect_frame(32'h1, 8'h51, 1'b0, 1'b0, 8'h00, -1);
      check("D_drop_cnt", {16'd0, drop_cnt}, 32'd0);

      // Reset on the fifth byte of a frame
      do_reset();
      start_frame(8'h61);
      for (int k = 0; k < 5; k++) begin
         in_valid = (k == 1); in_data = mk(8'h99);
         check("E_tdata", {24'd0, m_tdata}, {24'd0, exp_byte(32'h0, 8'h61, k)});
         if (k == 3) check("E_drop_pre", {16'd0, drop_cnt}, 32'd1);
         if (k == 4) begin
            srst = 1'b1; in_valid = 1'b1; in_data = mk(8'h77);
         end
         @(negedge clk);
      end
      srst = 1'b0; in_valid = 1'b0;
      check("E_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("E_tlast",  {31'd0, m_tlast},  32'd0);
      check("E_busy",   {31'd0, busy},     32'd0);
      check("E_drop",   {16'd0, drop_cnt}, 32'd0);
      @(negedge clk);
      check("E_still_idle", {31'd0, m_tvalid}, 32'd0);
      start_frame(8'h71);
      expect_frame(32'h0, 8'h71, 1'b0, 1'b0, 8'h00, -1);

      // drop_cnt saturation under a permanently stalled frame
      do_reset();
      start_frame(8'hB1);
      m_tready = 1'b0; in_valid = 1'b1; in_data = mk(8'h99);
      repeat (65534) @(negedge clk);
      check("F_drop_fffe", {16'd0, drop_cnt}, 32'h0000FFFE);
      repeat (6) @(negedge clk);
      check("F_drop_sat", {16'd0, drop_cnt}, 32'h0000FFFF);
      check("F_tvalid_held", {31'd0, m_tvalid}, 32'd1);
      check("F_tdata_held", {24'd0, m_tdata}, {24'd0, exp_byte(32'h0, 8'hB1, 0)});
      in_valid = 1'b0;
      expect_frame(32'h0, 8'hB1, 1'b0, 1'b0, 8'h00, -1);
      check("F_drop_final", {16'd0, drop_cnt}, 32'h0000FFFF);

      // Three frames back-to-back
      do_reset();
      start_frame(8'h81);
      expect_frame(32'h0, 8'h81, 1'b0, 1'b1, 8'h91, -1);
      expect_frame(32'h1, 8'h91, 1'b0, 1'b1, 8'hA1, -1);
      expect_frame(32'h2, 8'hA1, 1'b0, 1'b0, 8'h00, -1);
      check("G_idle_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("G_drop_cnt", {16'd0, drop_cnt}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
